// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the 10-bit-frame SPI master.
// SPI_FRAME_MASTER_SEQ_CHK_EN enables the address/data sequence check that uses seq_violation().
package spi_frame_pkg;

  // state      | meaning
  // ST_IDLE    | SS_n high, ready for a command
  // ST_START   | SS_n low, first copy of cmd[9]
  // ST_CMD     | cmd[9] held for the slave's command-check cycle
  // ST_SHIFT   | cmd[9:0] serialised MSB first
  // ST_WAIT_RD | SS_n low, waiting for the slave's read latency
  // ST_RECV    | 8 MISO samples, MSB first
  // ST_GAP     | SS_n high for the inter-frame gap
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT_RD,
    ST_RECV,
    ST_GAP
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int RD_BITS    = 8;

  // A read-data frame needs a pending address; a second address frame would overwrite one.
  function automatic logic seq_violation(input logic [1:0] kind, input logic addr_pend);
    return ((kind == CMD_RD_DATA) && !addr_pend) || ((kind == CMD_RD_ADDR) && addr_pend);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable 4-bit down-counter; done_o is high while the count sits at zero.
module spi_bit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_frame_master.sv
// Shared-clock SPI initiator: serialises 10-bit commands and captures 8-bit read replies.
// Optional SPI_FRAME_MASTER_SEQ_CHK_EN adds cmd_err and suppresses out-of-sequence frames.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_word,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
  output logic       cmd_err,
`endif
  input  logic       MISO
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(RD_BITS - 1);
  localparam logic [3:0] WAIT_LOAD  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [9:0]  shift_q, shift_d;
  logic [1:0]  kind_q, kind_d;
  logic [6:0]  rd_shift_q, rd_shift_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        cnt_load;
  logic [3:0]  cnt_val;
  logic        cnt_done;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
  logic        pend_q, pend_d;
  logic        err_q, err_d;
`endif

  spi_bit_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    kind_d     = kind_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    cnt_load   = 1'b0;
    cnt_val    = 4'd0;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
    pend_d     = pend_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        if (cmd_valid && ready_q) begin
          shift_d = cmd_word;
          kind_d  = cmd_word[9:8];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
          ss_n_d  = 1'b0;
          mosi_d  = cmd_word[9];
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
          if (seq_violation(cmd_word[9:8], pend_q)) begin
            state_d  = ST_GAP;
            ss_n_d   = 1'b1;
            mosi_d   = 1'b0;
            err_d    = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
          end else if (cmd_word[9:8] == CMD_RD_ADDR) begin
            pend_d = 1'b1;
          end else if (cmd_word[9:8] == CMD_RD_DATA) begin
            pend_d = 1'b0;
          end
`endif
        end
      end
      ST_START: begin
        state_d = ST_CMD;
        mosi_d  = shift_q[9];
      end
      ST_CMD: begin
        state_d  = ST_SHIFT;
        mosi_d   = shift_q[9];
        cnt_load = 1'b1;
        cnt_val  = SHIFT_LOAD;
      end
      ST_SHIFT: begin
        if (!cnt_done) begin
          mosi_d  = shift_q[8];
          shift_d = {shift_q[8:0], 1'b0};
        end else if (kind_q == CMD_RD_DATA) begin
          state_d  = ST_WAIT_RD;
          mosi_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = WAIT_LOAD;
        end else begin
          state_d  = ST_GAP;
          ss_n_d   = 1'b1;
          mosi_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
      end
      ST_WAIT_RD: begin
        if (cnt_done) begin
          state_d  = ST_RECV;
          cnt_load = 1'b1;
          cnt_val  = RECV_LOAD;
        end
      end
      ST_RECV: begin
        rd_shift_d = {rd_shift_q[5:0], MISO};
        if (cnt_done) begin
          rd_data_d  = {rd_shift_q, MISO};
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          state_d    = ST_GAP;
          cnt_load   = 1'b1;
          cnt_val    = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 10'd0;
      kind_q     <= 2'd0;
      rd_shift_q <= 7'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      kind_q     <= kind_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
      pend_q     <= pend_d;
      err_q      <= err_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
  assign cmd_err   = err_q;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed + random bench for spi_frame_master: two instances (read latency 3 and 5) share commands.
module tb_spi_frame_master;

  localparam int LAT_A = 3;
  localparam int LAT_B = 5;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [9:0] cmd_word;
  logic       miso_a, miso_b;
  logic       ready_a, rdv_a, busy_a, ss_a, mosi_a, err_a;
  logic       ready_b, rdv_b, busy_b, ss_b, mosi_b, err_b;
  logic [7:0] rdd_a, rdd_b;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rd_a = 8'd0;
  logic [7:0] exp_rd_b = 8'd0;
  bit         pend = 1'b0;

  always #5 clk = ~clk;

  spi_frame_master #(.RD_LATENCY(LAT_A), .GAP_CYCLES(GAP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a), .cmd_word(cmd_word),
    .rd_valid(rdv_a), .rd_data(rdd_a), .busy(busy_a), .SS_n(ss_a), .MOSI(mosi_a),
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
    .cmd_err(err_a),
`endif
    .MISO(miso_a)
  );

  spi_frame_master #(.RD_LATENCY(LAT_B), .GAP_CYCLES(GAP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b), .cmd_word(cmd_word),
    .rd_valid(rdv_b), .rd_data(rdd_b), .busy(busy_b), .SS_n(ss_b), .MOSI(mosi_b),
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
    .cmd_err(err_b),
`endif
    .MISO(miso_b)
  );

`ifndef SPI_FRAME_MASTER_SEQ_CHK_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MISO bit presented by the slave in cycle k when its byte p starts at cycle s.
  function automatic logic wave(input int k, input int s, input logic [7:0] p);
    int i;
    i = k - s;
    if (i >= 0 && i < 8) return p[3'(7 - i)];
    return 1'b0;
  endfunction

  // Expected outputs for one DUT in cycle k after the accept edge.
  task automatic chk_dut(input string nm, input int k, input logic [9:0] c, input int ll,
                         input bit rd, input bit er, input logic [7:0] cap, input logic [7:0] prev,
                         input logic o_ss, input logic o_mosi, input logic o_busy,
                         input logic o_ready, input logic o_rdv, input logic [7:0] o_rdd,
                         input logic o_err);
    logic e_mosi;
    e_mosi = 1'b0;
    if (!er && k <= 12) e_mosi = (k <= 2) ? c[9] : c[4'(12 - k)];
    chk($sformatf("%s k=%0d SS_n", nm, k),  32'(o_ss),    32'((k >= 1 && k <= ll) ? 1'b0 : 1'b1));
    chk($sformatf("%s k=%0d MOSI", nm, k),  32'(o_mosi),  32'(e_mosi));
    chk($sformatf("%s k=%0d busy", nm, k),  32'(o_busy),  32'(k <= ll + GAP));
    chk($sformatf("%s k=%0d ready", nm, k), 32'(o_ready), 32'(k > ll + GAP));
    chk($sformatf("%s k=%0d rd_valid", nm, k), 32'(o_rdv), 32'(rd && k == ll + 1));
    chk($sformatf("%s k=%0d rd_data", nm, k), 32'(o_rdd), 32'((rd && k > ll) ? cap : prev));
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
    chk($sformatf("%s k=%0d cmd_err", nm, k), 32'(o_err), 32'(er && k == 1));
`endif
  endtask

  task automatic summary_and_fatal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "accept wait expired");
  endtask

  // Issue one command; off_b delays the B-side slave reply by that many cycles.
  task automatic run_frame(input logic [9:0] c, input logic [7:0] pat, input int off_b,
                           input bit hold, input bit expect_now);
    int waited, ll_a, ll_b, n, s_a, s_b;
    bit is_rd, er, rd_ok;
    logic [7:0] cap_a, cap_b;
    cmd_word  = c;
    cmd_valid = 1'b1;
    waited    = 0;
    while (ready_a !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      chk("accept_timeout", 32'(ready_a), 32'd1);
      summary_and_fatal();
    end
    if (expect_now) chk("accept_wait", 32'(waited), 32'd0);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;

    is_rd = (c[9:8] == 2'b11);
    er    = 1'b0;
`ifdef SPI_FRAME_MASTER_SEQ_CHK_EN
    er = (is_rd && !pend) || (c[9:8] == 2'b10 && pend);
    if (!er && c[9:8] == 2'b10) pend = 1'b1;
    if (!er && is_rd) pend = 1'b0;
`endif
    rd_ok = is_rd && !er;
    s_a   = 13 + LAT_A;
    s_b   = 13 + LAT_B + off_b;
    ll_a  = er ? 0 : (is_rd ? 12 + LAT_A + 8 : 12);
    ll_b  = er ? 0 : (is_rd ? 12 + LAT_B + 8 : 12);
    cap_a = 8'd0;
    cap_b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cap_a = {cap_a[6:0], wave(13 + LAT_A + i, s_a, pat)};
      cap_b = {cap_b[6:0], wave(13 + LAT_B + i, s_b, pat)};
    end
    n = ((ll_a > ll_b) ? ll_a : ll_b) + GAP + 1;

    for (int k = 1; k <= n; k++) begin
      miso_a = wave(k, s_a, pat);
      miso_b = wave(k, s_b, pat);
      @(negedge clk);
      chk_dut("A", k, c, ll_a, rd_ok, er, cap_a, exp_rd_a,
              ss_a, mosi_a, busy_a, ready_a, rdv_a, rdd_a, err_a);
      chk_dut("B", k, c, ll_b, rd_ok, er, cap_b, exp_rd_b,
              ss_b, mosi_b, busy_b, ready_b, rdv_b, rdd_b, err_b);
      if (k < n) begin
        @(posedge clk); #1;
      end
    end
    if (rd_ok) begin
      exp_rd_a = cap_a;
      exp_rd_b = cap_b;
    end
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, " SS_n"},     32'(ss_a),    32'd1);
    chk({nm, " MOSI"},     32'(mosi_a),  32'd0);
    chk({nm, " busy"},     32'(busy_a),  32'd0);
    chk({nm, " ready"},    32'(ready_a), 32'd0);
    chk({nm, " rd_valid"}, 32'(rdv_a),   32'd0);
    chk({nm, " rd_data"},  32'(rdd_a),   32'd0);
    chk({nm, " B SS_n"},   32'(ss_b),    32'd1);
    chk({nm, " B busy"},   32'(busy_b),  32'd0);
    chk({nm, " B rd_data"}, 32'(rdd_b),  32'd0);
    exp_rd_a = 8'd0;
    exp_rd_b = 8'd0;
    pend     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_word  = 10'd0;
    miso_a    = 1'b0;
    miso_b    = 1'b0;

    // Power-on reset, then cmd_ready rises one cycle after release.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("por ready_hold", 32'(ready_a), 32'd0);
    @(negedge clk);
    chk("por ready_rise", 32'(ready_a), 32'd1);
    @(posedge clk); #1;

    // Write address frame.
    run_frame(10'b00_1010_0101, 8'h00, 0, 1'b0, 1'b0);

    // Read address then read data with reply C3.
    run_frame(10'b10_0000_0111, 8'h00, 0, 1'b0, 1'b0);
    run_frame(10'b11_0000_0000, 8'hC3, 0, 1'b0, 1'b0);

    // Back-to-back writes with cmd_valid held high.
    run_frame(10'b01_0011_1100, 8'h00, 0, 1'b1, 1'b0);
    run_frame(10'b00_1111_0000, 8'h00, 0, 1'b0, 1'b1);

    // Latency-5 instance: aligned reply, then reply late by one cycle.
    run_frame(10'b10_0101_0101, 8'h00, 0, 1'b0, 1'b0);
    run_frame(10'b11_1000_0001, 8'h5A, 0, 1'b0, 1'b0);
    run_frame(10'b10_0000_0001, 8'h00, 0, 1'b0, 1'b0);
    run_frame(10'b11_0000_0010, 8'h5A, 1, 1'b0, 1'b0);

    // Reset during SHIFT bit 5 (cycle 8 after accept).
    cmd_word  = 10'b01_1100_0011;
    cmd_valid = 1'b1;
    while (ready_a !== 1'b1) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_state("midrst");
    @(posedge clk); #1;

    // First command after reset is a read-data frame with no pending address.
    run_frame(10'b11_0110_0110, 8'hA5, 0, 1'b0, 1'b0);
    run_frame(10'b10_0001_0001, 8'h00, 0, 1'b0, 1'b0);
    run_frame(10'b11_0010_0010, 8'h96, 0, 1'b0, 1'b0);
    run_frame(10'b00_1010_0101, 8'h00, 0, 1'b0, 1'b0);

    // Random commands and replies.
    for (int r = 0; r < 16; r++) begin
      run_frame(10'($urandom), 8'($urandom), int'($urandom_range(0, 1)),
                1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
